bus_mem_responder: RTL and testbench
====================================

Name: bus_mem_responder

Overview:
- Main-memory model on the downstream side of the direct-mapped cache controller's bus port.
- Services block-granular read (fetch) and write (write-back) requests: 32 blocks of 16 bits, fixed configurable latency, one-cycle done pulse.
- Also checks the bus protocol and flags violations, so it serves as both the system memory and the bus checker for cache verification.

Parameters:
- ADDR_W, 5, block address width; depth = 2**ADDR_W words.
- DATA_W, 16, block width; fixed at 16 (two 8-bit bytes).
- LATENCY, 4, cycles from request acceptance to bus_done; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- bus_rd  in  1  read (fetch) request, held until done.
- bus_wr  in  1  write (write-back) request, held until done.
- bus_addr  in  ADDR_W  block address.
- bus_wdata  in  DATA_W  write data from cache (cache's bus_dout).
- bus_rdata  out  DATA_W  read data to cache (cache's bus_din).
- bus_done  out  1  one-cycle completion pulse.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: reset (synchronous, active-high) and clock clk as decided. Reset forces state IDLE, bus_done=0, bus_rdata=0, proto_err=0, and latency counter 0.
- Reset also reinitialises memory: mem[a] = {a,3'b100, a,3'b000}. Byte at 6-bit processor address p = {a,w} therefore reads p*4 (w=1 selects [15:8]).
- Reset mid-transaction aborts it: no done, no memory write.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Exactly one of bus_rd/bus_wr high: latch op, bus_addr, and bus_wdata; load counter with LATENCY-1.
  - Next state is BUSY, or DONE directly if LATENCY=1.
  - Both high: ignore the request, set proto_err, stay IDLE.
- BUSY:
  - Decrement counter; move to DONE when counter reaches 1.
  - Latched values are used; later bus_addr/bus_wdata changes do not affect the transaction.
  - Request dropped, op changed, or bus_addr differing from latched address: set proto_err; transaction still completes.
- DONE:
  - bus_done=1 for exactly this cycle.
  - Read: bus_rdata = mem[latched addr] this cycle only; bus_rdata=0 in every other cycle.
  - Write: mem[latched addr] <= latched wdata on the clock edge ending DONE.
  - Next state is always IDLE.
- Latency: the request first seen at IDLE edge t produces bus_done high in cycle t+LATENCY.
- Back-to-back: the cache drops its request on the edge ending DONE and may present a new one in the following cycle. That request is accepted in IDLE with no extra gap; inter-done spacing is LATENCY+1 cycles.
- Read-after-write to the same address in consecutive transactions returns the new data.
- proto_err: sticky until reset; never blocks operation.
- Address range: addresses are full-range; no wrap or out-of-range case exists.

Optional Feature:
- Macro: MEM_STATS_EN.
- Defined: adds outputs rd_count and wr_count (16 bits each, reset 0). Each increments on the edge ending DONE for its op and saturates at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then bus_rd=1 with bus_addr=5'h03 from cycle 0 (LATENCY=4) -> bus_done=1 only in cycle 4; bus_rdata=16'h1C18 in that cycle and 0 in all other cycles.
- bus_wr=1, bus_addr=5'h03, bus_wdata=16'hBEEF -> done after 4 cycles; a following read of 5'h03 returns 16'hBEEF; a read of 5'h04 returns 16'h2420.
- Write-back to 5'h0A immediately followed by fetch of 5'h12 with no idle cycle -> two done pulses 5 cycles apart; fetch returns 16'h9490.
- bus_rd and bus_wr both high in IDLE -> no done pulse, proto_err=1, memory unchanged; proto_err stays 1 until reset.
- bus_addr changed from 5'h01 to 5'h02 during BUSY of a read -> done still at cycle 4 with data 16'h0C08, and proto_err=1.
- Reset asserted in BUSY of a write to 5'h07 with 16'h1234 -> no done pulse; read of 5'h07 returns 16'h3C38. With MEM_STATS_EN defined: 3 reads + 2 writes -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/bus_mem_if.sv
// Block-granular bus between the cache controller (master) and main memory (slave).
interface bus_mem_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic              bus_rd;
   logic              bus_wr;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_done;
   logic              proto_err;

   modport master (
      output bus_rd, bus_wr, bus_addr, bus_wdata,
      input  bus_rdata, bus_done, proto_err
   );

   modport slave (
      input  bus_rd, bus_wr, bus_addr, bus_wdata,
      output bus_rdata, bus_done, proto_err
   );
endinterface

// File: rtl/bus_mem_responder.sv
// Main-memory model and bus protocol checker behind the cache bus port.
// Define MEM_STATS_EN to add saturating rd_count/wr_count outputs.
module bus_mem_responder #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   bus_mem_if.slave    bus
`ifdef MEM_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                op_rd_q, op_rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                perr_q, perr_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];
   logic                req_ok;
`ifdef MEM_STATS_EN
   logic [15:0]         rd_count_q, rd_count_d;
   logic [15:0]         wr_count_q, wr_count_d;
`endif

   // The held request must match the latched op exactly, with no stray opposite op.
   assign req_ok = op_rd_q ? (bus.bus_rd && !bus.bus_wr) : (bus.bus_wr && !bus.bus_rd);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_rd_d = op_rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      perr_d  = perr_q;
      mem_d   = mem_q;
`ifdef MEM_STATS_EN
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.bus_rd ^ bus.bus_wr) begin
               op_rd_d = bus.bus_rd;
               addr_d  = bus.bus_addr;
               wdata_d = bus.bus_wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? DONE : BUSY;
            end else if (bus.bus_rd && bus.bus_wr) begin
               perr_d = 1'b1;
            end
         end
         BUSY: begin
            if (!req_ok || (bus.bus_addr != addr_q)) perr_d = 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            if (!op_rd_q) mem_d[addr_q] = wdata_q;
`ifdef MEM_STATS_EN
            if (op_rd_q && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
            if (!op_rd_q && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_rd_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         perr_q  <= 1'b0;
         // Byte at processor address {a,w} holds {a,w}*4.
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= DATA_W'({8'(i * 8 + 4), 8'(i * 8)});
`ifdef MEM_STATS_EN
         rd_count_q <= '0;
         wr_count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_rd_q <= op_rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         perr_q  <= perr_d;
         mem_q   <= mem_d;
`ifdef MEM_STATS_EN
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
`endif
      end
   end

   assign bus.bus_done  = (state_q == DONE);
   assign bus.bus_rdata = ((state_q == DONE) && op_rd_q) ? mem_q[addr_q] : '0;
   assign bus.proto_err = perr_q;
`ifdef MEM_STATS_EN
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: driver pushes expected responses, monitor checks each done.
module tb_bus_mem_responder;
   localparam int AW  = 5;
   localparam int DW  = 16;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bus_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef MEM_STATS_EN
   logic [15:0] rd_count, wr_count;
`endif

   bus_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MEM_STATS_EN
      ,
      .rd_count (rd_count),
      .wr_count (wr_count)
`endif
   );

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pops one expected response; outside done, rdata must read 0.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (bus.bus_done === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               check("rdata", {16'h0, bus.bus_rdata}, {16'h0, e.data});
               check("done_cycle", cyc, e.cyc);
            end
         end else begin
            check("rdata_idle", {16'h0, bus.bus_rdata}, 32'h0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one transaction (entered at posedge+1) and hold it until done.
   task automatic issue(input bit rd, input logic [4:0] a, input logic [15:0] wd,
                        input logic [15:0] exp, input bit chg = 1'b0, input logic [4:0] a2 = '0);
      exp_t e;
      bit   done;
      bus.bus_rd    = rd;
      bus.bus_wr    = !rd;
      bus.bus_addr  = a;
      bus.bus_wdata = wd;
      e.data = rd ? exp : 16'h0;
      e.cyc  = cyc + LAT;
      sbq.push_back(e);
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.bus_done === 1'b1) done = 1'b1;
         else if (chg && i == 1) bus.bus_addr = a2;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done expected done for addr %h", a);
      end
      @(posedge clk);
      #1;
      bus.bus_rd = 1'b0;
      bus.bus_wr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.bus_rd    = 1'b0;
      bus.bus_wr    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_wdata = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      check("reset_done", {31'h0, bus.bus_done}, 32'h0);
      check("reset_rdata", {16'h0, bus.bus_rdata}, 32'h0);
      check("reset_perr", {31'h0, bus.proto_err}, 32'h0);

      // Basic fetch, write-back, read-after-write
      issue(1'b1, 5'h03, 16'h0000, 16'h1C18);
      idle(2);
      issue(1'b0, 5'h03, 16'hBEEF, 16'h0);
      issue(1'b1, 5'h03, 16'h0000, 16'hBEEF);
      issue(1'b1, 5'h04, 16'h0000, 16'h2420);

      // Back-to-back write then fetch with no idle cycle
      issue(1'b0, 5'h0A, 16'h5A5A, 16'h0);
      issue(1'b1, 5'h12, 16'h0000, 16'h9490);
      issue(1'b1, 5'h0A, 16'h0000, 16'h5A5A);
      idle(1);
      check("perr_clean", {31'h0, bus.proto_err}, 32'h0);

      // Both ops at once: ignored, flagged
      bus.bus_rd    = 1'b1;
      bus.bus_wr    = 1'b1;
      bus.bus_addr  = 5'h03;
      bus.bus_wdata = 16'h0000;
      idle(1);
      bus.bus_rd = 1'b0;
      bus.bus_wr = 1'b0;
      idle(6);
      check("perr_both", {31'h0, bus.proto_err}, 32'h1);
      issue(1'b1, 5'h03, 16'h0000, 16'hBEEF);
      check("perr_sticky", {31'h0, bus.proto_err}, 32'h1);

      // Address change during BUSY: latched address wins, flagged
      do_reset();
      idle(1);
      check("perr_after_reset", {31'h0, bus.proto_err}, 32'h0);
      issue(1'b1, 5'h01, 16'h0000, 16'h0C08, 1'b1, 5'h02);
      check("perr_addr_chg", {31'h0, bus.proto_err}, 32'h1);

      // Reset in BUSY of a write: aborted, memory back to init pattern
      do_reset();
      idle(1);
      bus.bus_wr    = 1'b1;
      bus.bus_addr  = 5'h07;
      bus.bus_wdata = 16'h1234;
      idle(2);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      bus.bus_wr = 1'b0;
      idle(6);
      check("perr_abort", {31'h0, bus.proto_err}, 32'h0);
      issue(1'b1, 5'h07, 16'h0000, 16'h3C38);
      issue(1'b0, 5'h01, 16'h1111, 16'h0);
      issue(1'b0, 5'h02, 16'h2222, 16'h0);
      issue(1'b1, 5'h01, 16'h0000, 16'h1111);
      issue(1'b1, 5'h02, 16'h0000, 16'h2222);
`ifdef MEM_STATS_EN
      check("rd_count", {16'h0, rd_count}, 32'd3);
      check("wr_count", {16'h0, wr_count}, 32'd2);
`endif
      idle(3);
      check("sb_drained", sbq.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
